// File: rtl/zx_pkg.sv
// Shared constants for the +3 I/O responder: port decode masks, frame defaults
// and register reset values.
package zx_pkg;

    localparam logic [15:0] FE_MASK     = 16'h0001;
    localparam logic [15:0] FE_MATCH    = 16'h0000;
    localparam logic [15:0] P7FFD_MASK  = 16'hC002;
    localparam logic [15:0] P7FFD_MATCH = 16'h4000;
    localparam logic [15:0] P1FFD_MASK  = 16'hF002;
    localparam logic [15:0] P1FFD_MATCH = 16'h1000;

    localparam int HCOUNT_DEF  = 228;
    localparam int VCOUNT_DEF  = 311;
    localparam int IRQLINE_DEF = 0;
    localparam int IRQLEN_DEF  = 32;

    localparam logic [7:0] Q_IDLE     = 8'hFF;
    localparam logic [7:0] PAGE_RST   = 8'h00;
    localparam logic [2:0] BORDER_RST = 3'd0;

    typedef struct packed {
        logic fe;
        logic p7ffd;
        logic p1ffd;
    } port_sel_t;

    function automatic logic port_hit(input logic [15:0] addr,
                                      input logic [15:0] mask,
                                      input logic [15:0] match);
        return (addr & mask) == match;
    endfunction

    // Partial decode: one address may select several ports at once.
    function automatic port_sel_t decode_port(input logic [15:0] addr);
        port_sel_t sel;
        sel.fe    = port_hit(addr, FE_MASK, FE_MATCH);
        sel.p7ffd = port_hit(addr, P7FFD_MASK, P7FFD_MATCH);
        sel.p1ffd = port_hit(addr, P1FFD_MASK, P1FFD_MATCH);
        return sel;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Line/frame position counters advanced once per T-state, producing the
// registered active-low frame interrupt.
module frame_timer #(
    parameter int HCOUNT  = 228,
    parameter int VCOUNT  = 311,
    parameter int IRQLINE = 0,
    parameter int IRQLEN  = 32
) (
    input  logic clock,
    input  logic reset,
    input  logic pe,
    output logic irq
);

    localparam int HW = $clog2(HCOUNT);
    localparam int VW = $clog2(VCOUNT);

    localparam logic [HW-1:0] H_LAST  = HW'(HCOUNT - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(VCOUNT - 1);
    localparam logic [VW-1:0] IRQ_V   = VW'(IRQLINE);
    localparam logic [HW:0]   IRQ_END = (HW + 1)'(IRQLEN);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          irq_q, irq_d;

    always_comb begin
        h_d   = h_q;
        v_d   = v_q;
        irq_d = irq_q;
        if (pe) begin
            // irq reflects the position being left on this T-state.
            irq_d = !((v_q == IRQ_V) && ({1'b0, h_q} < IRQ_END));
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            h_q   <= '0;
            v_q   <= '0;
            irq_q <= 1'b1;
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule

// File: rtl/ula_io.sv
// Z80 I/O responder for the +3: latches ports FE/7FFD/1FFD, answers FE reads
// with keyboard and EAR data, and hosts the frame interrupt timer.
module ula_io
    import zx_pkg::*;
#(
    parameter int HCOUNT  = HCOUNT_DEF,
    parameter int VCOUNT  = VCOUNT_DEF,
    parameter int IRQLINE = IRQLINE_DEF,
    parameter int IRQLEN  = IRQLEN_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ne,
    input  logic        pe,
    input  logic        iorq,
    input  logic        rd,
    input  logic        wr,
    input  logic [15:0] a,
    input  logic [7:0]  d,
    output logic [7:0]  q,
    output logic        irq,
    input  logic [4:0]  kcol,
    output logic [7:0]  krow,
    input  logic        ear,
    output logic [2:0]  border,
    output logic        mic,
    output logic        speaker,
    output logic [7:0]  p7ffd,
    output logic [7:0]  p1ffd
);

    port_sel_t  sel;
    logic       wr_cyc;
    logic       rd_cyc;
    logic       commit;
    logic       unused_ne;

    logic [2:0] border_q, border_d;
    logic       mic_q, mic_d;
    logic       spk_q, spk_d;
    logic [7:0] p7ffd_q, p7ffd_d;
    logic [7:0] p1ffd_q, p1ffd_d;
    logic       lock_q, lock_d;
    logic       done_q, done_d;
    logic [7:0] q_q, q_d;

    assign unused_ne = ne;

    assign sel    = decode_port(a);
    assign wr_cyc = !iorq && !wr;
    assign rd_cyc = !iorq && !rd;
    // done blocks repeat commits while the CPU stretches one OUT over several T-states.
    assign commit = pe && wr_cyc && !done_q;

    always_comb begin
        border_d = border_q;
        mic_d    = mic_q;
        spk_d    = spk_q;
        p7ffd_d  = p7ffd_q;
        p1ffd_d  = p1ffd_q;
        lock_d   = lock_q;
        done_d   = done_q;
        q_d      = q_q;

        if (pe) begin
            if (iorq) begin
                done_d = 1'b0;
            end else if (!wr) begin
                done_d = 1'b1;
            end
            q_d = (rd_cyc && sel.fe) ? {1'b1, ear, 1'b1, kcol} : Q_IDLE;
        end

        if (commit) begin
            if (sel.fe) begin
                border_d = d[2:0];
                mic_d    = d[3];
                spk_d    = d[4];
            end
            // Lock freezes both paging registers until the next reset.
            if (sel.p7ffd && !lock_q) begin
                p7ffd_d = d;
                lock_d  = d[5];
            end
            if (sel.p1ffd && !lock_q) begin
                p1ffd_d = d;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            border_q <= BORDER_RST;
            mic_q    <= 1'b0;
            spk_q    <= 1'b0;
            p7ffd_q  <= PAGE_RST;
            p1ffd_q  <= PAGE_RST;
            lock_q   <= 1'b0;
            done_q   <= 1'b0;
            q_q      <= Q_IDLE;
        end else begin
            border_q <= border_d;
            mic_q    <= mic_d;
            spk_q    <= spk_d;
            p7ffd_q  <= p7ffd_d;
            p1ffd_q  <= p1ffd_d;
            lock_q   <= lock_d;
            done_q   <= done_d;
            q_q      <= q_d;
        end
    end

    frame_timer #(
        .HCOUNT  (HCOUNT),
        .VCOUNT  (VCOUNT),
        .IRQLINE (IRQLINE),
        .IRQLEN  (IRQLEN)
    ) u_frame_timer (
        .clock (clock),
        .reset (reset),
        .pe    (pe),
        .irq   (irq)
    );

    assign q       = q_q;
    assign krow    = a[15:8];
    assign border  = border_q;
    assign mic     = mic_q;
    assign speaker = spk_q;
    assign p7ffd   = p7ffd_q;
    assign p1ffd   = p1ffd_q;

endmodule

// File: tb/tb_ula_io.sv
// Scoreboard bench for ula_io: stimulus pushes expected outputs, a negedge
// monitor pops and compares; irq is compared every cycle against a frame model.
module tb_ula_io;

    localparam int FRAME  = 228 * 311;
    localparam int IRQW   = 32;

    logic        clock = 1'b0;
    logic        reset, ne, pe, iorq, rd, wr, ear;
    logic [15:0] a;
    logic [7:0]  d, q, krow, p7ffd, p1ffd;
    logic [4:0]  kcol;
    logic [2:0]  border;
    logic        irq, mic, speaker;

    always #5 clock = ~clock;

    ula_io dut (
        .clock(clock), .reset(reset), .ne(ne), .pe(pe), .iorq(iorq), .rd(rd), .wr(wr),
        .a(a), .d(d), .q(q), .irq(irq), .kcol(kcol), .krow(krow), .ear(ear),
        .border(border), .mic(mic), .speaker(speaker), .p7ffd(p7ffd), .p1ffd(p1ffd)
    );

    typedef struct {
        int         due;
        int         sel;
        logic [7:0] exp;
        string      name;
    } chk_t;

    chk_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   k     = 0;
    int   falls[$];
    int   low_cnt = 0;
    int   irq_prints = 0;
    logic irq_prev = 1'b1;
    logic armed = 1'b0;

    // Behavioural machine state derived from the port rules.
    logic [2:0] border_m;
    logic       mic_m, spk_m, lock_m;
    logic [7:0] p7_m, p1_m;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reset) k <= 0;
        else if (pe) k <= k + 1;
    end

    function automatic logic [7:0] dut_val(input int s);
        case (s)
            0: return q;
            1: return {5'b0, border};
            2: return {7'b0, mic};
            3: return {7'b0, speaker};
            4: return p7ffd;
            5: return p1ffd;
            default: return krow;
        endcase
    endfunction

    // Interrupt low for the first IRQW T-states of every frame since reset.
    function automatic logic irq_exp(input int kk);
        if (kk == 0) return 1'b1;
        return (((kk - 1) % FRAME) < IRQW) ? 1'b0 : 1'b1;
    endfunction

    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            chk_t c;
            c = sb.pop_front();
            total++;
            if (dut_val(c.sel) !== c.exp) begin
                bad++;
                $display("FAIL %s: got %h want %h", c.name, dut_val(c.sel), c.exp);
            end
        end
    end

    always @(negedge clock) begin
        if (armed) begin
            total++;
            if (irq !== irq_exp(k)) begin
                bad++;
                if (irq_prints < 10) begin
                    irq_prints++;
                    $display("FAIL irq at pe=%0d: got %b want %b", k, irq, irq_exp(k));
                end
            end
            if (irq_prev === 1'b1 && irq === 1'b0) falls.push_back(k);
            if (irq === 1'b0) low_cnt <= low_cnt + 1;
            irq_prev <= irq;
        end
    end

    task automatic push(input int s, input logic [7:0] e, input string nm);
        chk_t c;
        c.due = cyc; c.sel = s; c.exp = e; c.name = nm;
        sb.push_back(c);
    endtask

    task automatic push_state(input string tag);
        push(0, 8'hFF, {tag, ".q"});
        push(1, {5'b0, border_m}, {tag, ".border"});
        push(2, {7'b0, mic_m}, {tag, ".mic"});
        push(3, {7'b0, spk_m}, {tag, ".speaker"});
        push(4, p7_m, {tag, ".p7ffd"});
        push(5, p1_m, {tag, ".p1ffd"});
    endtask

    task automatic check_int(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic clk1(input logic pe_v);
        pe = pe_v;
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        border_m = 3'd0; mic_m = 1'b0; spk_m = 1'b0;
        p7_m = 8'h00; p1_m = 8'h00; lock_m = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clk1(1'b1);
        reset = 1'b0;
        model_reset();
        push_state("reset");
    endtask

    task automatic io_write(input logic [15:0] ad, input logic [7:0] dv, input int npe);
        logic is_fe, is_7, is_1;
        is_fe = (ad[0] == 1'b0);
        is_7  = (ad[15] == 1'b0) && (ad[14] == 1'b1) && (ad[1] == 1'b0);
        is_1  = (ad[15:12] == 4'b0001) && (ad[1] == 1'b0);
        a = ad; d = dv; iorq = 1'b0; wr = 1'b0;
        clk1(1'b1);
        if (is_fe) begin
            border_m = dv[2:0]; mic_m = dv[3]; spk_m = dv[4];
        end
        if (!lock_m) begin
            if (is_1) p1_m = dv;
            if (is_7) begin
                p7_m = dv; lock_m = dv[5];
            end
        end
        push_state("wr");
        d = ~dv;
        for (int i = 1; i < npe; i++) begin
            clk1(1'b0);
            clk1(1'b1);
        end
        push_state("wr_held");
        iorq = 1'b1; wr = 1'b1;
        clk1(1'b1);
    endtask

    task automatic io_read(input logic [15:0] ad);
        a = ad; iorq = 1'b0; rd = 1'b0;
        clk1(1'b1);
        push(0, (ad[0] == 1'b0) ? {1'b1, ear, 1'b1, kcol} : 8'hFF, "rd.q");
        push(6, ad[15:8], "rd.krow");
        iorq = 1'b1; rd = 1'b1;
        clk1(1'b1);
        push(0, 8'hFF, "rd_end.q");
    endtask

    initial begin
        int nf;
        reset = 1'b1; ne = 1'b0; pe = 1'b0; iorq = 1'b1; rd = 1'b1; wr = 1'b1;
        a = 16'h0000; d = 8'h00; kcol = 5'h1F; ear = 1'b0;
        model_reset();
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        armed = 1'b1;
        push_state("init");

        // Full frame plus the start of the next one.
        pe = 1'b1;
        repeat (FRAME + 40) @(posedge clock);
        #1;
        pe = 1'b0;
        check_int("irq_fall_count", falls.size(), 2);
        if (falls.size() >= 2) begin
            check_int("irq_first_fall", falls[0], 1);
            check_int("irq_period", falls[1] - falls[0], FRAME);
        end
        check_int("irq_low_cycles", low_cnt, 2 * IRQW);

        io_write(16'h00FE, 8'h05, 3);
        io_write(16'h7FFD, 8'h27, 1);
        io_write(16'h7FFD, 8'h00, 2);
        io_write(16'h1FFD, 8'h04, 1);

        do_reset();
        io_write(16'h1FFD, 8'h04, 1);

        kcol = 5'h1E; ear = 1'b1;
        io_read(16'hFEFE);
        io_read(16'h00FF);

        for (int i = 0; i < 60; i++) begin
            int op;
            logic [15:0] ad;
            op = $urandom_range(0, 9);
            case ($urandom_range(0, 4))
                0: ad = {8'($urandom), 8'hFE};
                1: ad = 16'h7FFD;
                2: ad = 16'h1FFD;
                3: ad = 16'h3FFC;
                default: ad = 16'($urandom);
            endcase
            kcol = 5'($urandom);
            ear  = 1'($urandom);
            if (op == 0) do_reset();
            else if (op <= 4) io_read(ad);
            else io_write(ad, 8'($urandom), $urandom_range(1, 3));
        end

        // Reset landing at h=100, v=5 with a write pending on that edge.
        do_reset();
        io_write(16'h00FE, 8'h1B, 1);
        io_write(16'h7FFD, 8'h13, 1);
        while (k < 5 * 228 + 100) clk1(1'b1);
        nf = falls.size();
        a = 16'h00FE; d = 8'h07; iorq = 1'b0; wr = 1'b0; reset = 1'b1;
        clk1(1'b1);
        reset = 1'b0; iorq = 1'b1; wr = 1'b1;
        model_reset();
        push_state("midrst");
        clk1(1'b1); clk1(1'b1); clk1(1'b1);
        check_int("midrst_fall_count", falls.size(), nf + 1);
        if (falls.size() == nf + 1) check_int("midrst_fall_pos", falls[nf], 1);

        clk1(1'b0); clk1(1'b0);
        check_int("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
